mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 valid_i  in  1  EX presents a valid instruction this cycle.
REQ-004 ALUop_i  in  5  operation code from EX: 5'b10100 = lw, 5'b10101 = sw, all others = non-memory.
REQ-005 MemAddr_i  in  32  effective address computed by EX.
REQ-006 StoreData_i  in  32  store operand (EX Result).
REQ-007 WriteData_i  in  32  ALU/link result from EX.
REQ-008 WriteDataNum_i  in  5  destination register index.
REQ-009 WriteReg_i  in  1  register-write enable from EX.
REQ-010 stall_o  out  1  holds EX inputs steady; upstream does not advance while high.
REQ-011 mem_req_o, mem_we_o  out  1 each  data-memory request and write enable.
REQ-012 mem_addr_o, mem_wdata_o  out  32 each  data-memory address and store data.
REQ-013 mem_rdata_i  in  32;  mem_ack_i  in  1  memory read data and completion strobe.
REQ-014 wb_valid_o  out  1  one-cycle writeback strobe.
REQ-015 WriteReg_o  out  1;  WriteDataNum_o  out  5;  WriteData_o  out  32  writeback bundle.
REQ-016 err_o  out  1  one-cycle pulse on misaligned access or memory timeout.

Function
REQ-017 States: IDLE and WAIT; stall_o SHALL equal (state == WAIT), decoded from state only.
REQ-018 IDLE, valid_i = 1, non-memory op: next edge registers wb_valid_o = 1, WriteReg_o = WriteReg_i, WriteDataNum_o = WriteDataNum_i, WriteData_o = WriteData_i; 1-cycle latency; state stays IDLE.
REQ-019 IDLE, valid_i = 1, lw/sw with MemAddr_i[1:0] = 2'b00: latch the address, store data, destination, and the lw/sw flag; next edge enters WAIT with mem_req_o = 1, mem_we_o = 1 for sw and 0 for lw.
REQ-020 mem_req_o, mem_we_o, mem_addr_o, and mem_wdata_o SHALL be registered and held constant throughout WAIT; mem_req_o is 0 in IDLE.
REQ-021 WAIT with mem_ack_i = 1 sampled: next edge returns to IDLE, drops mem_req_o, and pulses wb_valid_o.
REQ-021a On lw completion: WriteData_o = mem_rdata_i sampled with ack, WriteReg_o = latched WriteReg_i.
REQ-021b On sw completion: WriteReg_o = 0, WriteData_o = 0.
REQ-022 valid_i and all EX inputs SHALL be ignored while in WAIT; the instruction held upstream is accepted on the first IDLE cycle.
REQ-023 Timeout: a 4-bit counter clears on WAIT entry and increments each WAIT cycle without ack. If it is at 15 and ack is 0, next edge: IDLE, mem_req_o = 0, err_o = 1, wb_valid_o = 1 with WriteReg_o = 0. Ack arriving in the same cycle as count 15 SHALL complete normally, with no error.
REQ-024 Misaligned lw/sw (MemAddr_i[1:0] != 0) in IDLE: no memory request, state stays IDLE, next edge pulses err_o = 1 and wb_valid_o = 1 with WriteReg_o = 0.
REQ-025 IDLE with valid_i = 0: next edge wb_valid_o = 0, WriteReg_o = 0, err_o = 0; WriteDataNum_o and WriteData_o hold their previous values.
REQ-026 WriteReg_o SHALL be 0 whenever wb_valid_o = 0.
REQ-027 mem_ack_i seen in IDLE SHALL be ignored.

Reset
REQ-028 rst = 1 SHALL immediately, without a clock, force state = IDLE, counter = 0, and all outputs to 0, including stall_o and mem_req_o.
REQ-029 rst asserted during WAIT SHALL abandon the access with no wb_valid_o or err_o pulse. After release, the block accepts a new instruction on the first edge.

Verification
REQ-030 add: valid_i = 1, ALUop_i = 01101, WriteData_i = 0x00000007, WriteDataNum_i = 5, WriteReg_i = 1 -> next cycle wb_valid_o = 1, WriteData_o = 7, WriteDataNum_o = 5, stall_o never high.
REQ-031 lw: MemAddr_i = 0x00000010, ack 3 cycles after mem_req_o rises, mem_rdata_i = 0xDEADBEEF -> mem_addr_o = 0x10, mem_we_o = 0, stall_o high for 3 cycles, then wb_valid_o = 1 with WriteData_o = 0xDEADBEEF.
REQ-032 sw: MemAddr_i = 0x00000020, StoreData_i = 0x12345678, immediate ack -> mem_we_o = 1, mem_wdata_o = 0x12345678, then wb_valid_o = 1 with WriteReg_o = 0.
REQ-033 lw with MemAddr_i = 0x00000013 -> mem_req_o stays 0, next cycle err_o = 1, wb_valid_o = 1, WriteReg_o = 0.
REQ-034 lw with no ack -> mem_req_o high for exactly 16 cycles, then err_o pulses; a second run with ack on the 16th cycle -> normal completion, err_o = 0.
REQ-035 rst pulsed on the 2nd WAIT cycle -> mem_req_o and stall_o fall asynchronously, no wb_valid_o; a following add completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage and the data memory.
// The master drives the request; the slave returns data and ack.
interface mem_stage_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: lw/sw issue with ack/timeout handling.
// Non-memory ops pass through to the writeback bundle in one cycle.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [4:0]  ALUop_i,
    input  logic [31:0] MemAddr_i,
    input  logic [31:0] StoreData_i,
    input  logic [31:0] WriteData_i,
    input  logic [4:0]  WriteDataNum_i,
    input  logic        WriteReg_i,
    output logic        stall_o,
    mem_stage_if.master mem,
    output logic        wb_valid_o,
    output logic        WriteReg_o,
    output logic [4:0]  WriteDataNum_o,
    output logic [31:0] WriteData_o,
    output logic        err_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [4:0] OP_LW = 5'b10100;
    localparam logic [4:0] OP_SW = 5'b10101;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_is_sw;
    logic [4:0]  r_num;
    logic        r_wen;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wb_valid;
    logic        r_wb_we;
    logic [4:0]  r_wb_num;
    logic [31:0] r_wb_data;
    logic        r_err;

    logic w_is_sw;
    logic w_is_mem;
    logic w_misalign;

    assign w_is_sw    = (ALUop_i == OP_SW);
    assign w_is_mem   = (ALUop_i == OP_LW) || w_is_sw;
    assign w_misalign = (MemAddr_i[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_is_sw    <= 1'b0;
            r_num      <= 5'd0;
            r_wen      <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_num   <= 5'd0;
            r_wb_data  <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            // Strobes default low; number/data hold unless rewritten.
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (!w_is_mem) begin
                            r_wb_valid <= 1'b1;
                            r_wb_we    <= WriteReg_i;
                            r_wb_num   <= WriteDataNum_i;
                            r_wb_data  <= WriteData_i;
                        end else if (w_misalign) begin
                            r_wb_valid <= 1'b1;
                            r_err      <= 1'b1;
                            r_wb_num   <= WriteDataNum_i;
                            r_wb_data  <= 32'd0;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'd0;
                            r_req   <= 1'b1;
                            r_we    <= w_is_sw;
                            r_addr  <= MemAddr_i;
                            r_wdata <= StoreData_i;
                            r_is_sw <= w_is_sw;
                            r_num   <= WriteDataNum_i;
                            r_wen   <= WriteReg_i;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem.mem_ack_i) begin
                        r_state    <= S_IDLE;
                        r_req      <= 1'b0;
                        r_we       <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_wb_num   <= r_num;
                        r_wb_we    <= r_is_sw ? 1'b0 : r_wen;
                        r_wb_data  <= r_is_sw ? 32'd0 : mem.mem_rdata_i;
                    end else if (r_cnt == 4'd15) begin
                        r_state    <= S_IDLE;
                        r_req      <= 1'b0;
                        r_we       <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_err      <= 1'b1;
                        r_wb_num   <= r_num;
                        r_wb_data  <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_o          = (r_state == S_WAIT);
    assign mem.mem_req_o    = r_req;
    assign mem.mem_we_o     = r_we;
    assign mem.mem_addr_o   = r_addr;
    assign mem.mem_wdata_o  = r_wdata;
    assign wb_valid_o       = r_wb_valid;
    assign WriteReg_o       = r_wb_we;
    assign WriteDataNum_o   = r_wb_num;
    assign WriteData_o      = r_wb_data;
    assign err_o            = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks are queued
// at issue and popped when wb_valid_o is seen.
module tb_mem_stage;

    localparam logic [4:0] OP_LW  = 5'b10100;
    localparam logic [4:0] OP_SW  = 5'b10101;
    localparam logic [4:0] OP_ADD = 5'b01101;

    typedef struct {
        logic        we;
        logic [4:0]  num;
        logic [31:0] data;
        logic        err;
        logic        full;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [4:0]  ALUop_i;
    logic [31:0] MemAddr_i;
    logic [31:0] StoreData_i;
    logic [31:0] WriteData_i;
    logic [4:0]  WriteDataNum_i;
    logic        WriteReg_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic        WriteReg_o;
    logic [4:0]  WriteDataNum_o;
    logic [31:0] WriteData_o;
    logic        err_o;

    mem_stage_if mem_bus ();

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .ALUop_i        (ALUop_i),
        .MemAddr_i      (MemAddr_i),
        .StoreData_i    (StoreData_i),
        .WriteData_i    (WriteData_i),
        .WriteDataNum_i (WriteDataNum_i),
        .WriteReg_i     (WriteReg_i),
        .stall_o        (stall_o),
        .mem            (mem_bus.master),
        .wb_valid_o     (wb_valid_o),
        .WriteReg_o     (WriteReg_o),
        .WriteDataNum_o (WriteDataNum_o),
        .WriteData_o    (WriteData_o),
        .err_o          (err_o)
    );

    int   n_chk;
    int   n_err;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid_o) begin
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_wreg", WriteReg_o, e.we);
                    chk("wb_err", err_o, e.err);
                    if (e.full) begin
                        chk("wb_num", WriteDataNum_o, e.num);
                        chk("wb_data", WriteData_o, e.data);
                    end
                end
            end else begin
                chk("idle_err", err_o, 1'b0);
                chk("idle_wreg", WriteReg_o, 1'b0);
            end
        end
    end

    function automatic exp_t mk(input logic we, input logic [4:0] num,
                                input logic [31:0] data,
                                input logic err, input logic full);
        exp_t e;
        e.we   = we;
        e.num  = num;
        e.data = data;
        e.err  = err;
        e.full = full;
        return e;
    endfunction

    // Called at posedge+1; instruction is sampled at the next edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] wd,
                         input logic [4:0] num, input logic we);
        chk("issue_idle", stall_o, 1'b0);
        valid_i        = 1'b1;
        ALUop_i        = op;
        MemAddr_i      = addr;
        StoreData_i    = sd;
        WriteData_i    = wd;
        WriteDataNum_i = num;
        WriteReg_i     = we;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // Ack in WAIT cycle d (0-based); d < 0 never acks. n = WAIT cycles.
    task automatic respond(input int d, input logic [31:0] rd,
                           input logic [31:0] addr, output int n);
        n = 0;
        while (mem_bus.mem_req_o && n < 40) begin
            chk("wait_stall", stall_o, 1'b1);
            chk("wait_addr", mem_bus.mem_addr_o, addr);
            if (n == d) begin
                mem_bus.mem_ack_i   = 1'b1;
                mem_bus.mem_rdata_i = rd;
            end else begin
                mem_bus.mem_ack_i   = 1'b0;
                mem_bus.mem_rdata_i = $urandom;
            end
            valid_i   = 1'b1;
            ALUop_i   = OP_ADD;
            MemAddr_i = $urandom;
            WriteReg_i = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) chk("wait_bound", 64'd1, 64'd0);
        mem_bus.mem_ack_i = 1'b0;
        valid_i = 1'b0;
        chk("done_stall", stall_o, 1'b0);
    endtask

    initial begin
        int n;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        valid_i = 1'b0;
        ALUop_i = 5'd0;
        MemAddr_i = 32'd0;
        StoreData_i = 32'd0;
        WriteData_i = 32'd0;
        WriteDataNum_i = 5'd0;
        WriteReg_i = 1'b0;
        mem_bus.mem_ack_i = 1'b0;
        mem_bus.mem_rdata_i = 32'd0;
        #3;
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_req", mem_bus.mem_req_o, 1'b0);
        chk("rst_wb", wb_valid_o, 1'b0);
        chk("rst_data", WriteData_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // add passes through in one cycle, then data holds
        sb.push_back(mk(1'b1, 5'd5, 32'd7, 1'b0, 1'b1));
        issue(OP_ADD, 32'h0, 32'h0, 32'd7, 5'd5, 1'b1);
        chk("add_stall", stall_o, 1'b0);
        @(posedge clk);
        #1;
        chk("hold_valid", wb_valid_o, 1'b0);
        chk("hold_data", WriteData_o, 32'd7);
        chk("hold_num", WriteDataNum_o, 5'd5);

        // ack while idle does nothing
        mem_bus.mem_ack_i = 1'b1;
        @(posedge clk);
        #1;
        mem_bus.mem_ack_i = 1'b0;
        chk("idle_ack_req", mem_bus.mem_req_o, 1'b0);
        chk("idle_ack_stall", stall_o, 1'b0);

        // lw with ack in third WAIT cycle
        sb.push_back(mk(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b1));
        issue(OP_LW, 32'h10, 32'h0, 32'h0, 5'd3, 1'b1);
        chk("lw_req", mem_bus.mem_req_o, 1'b1);
        chk("lw_we", mem_bus.mem_we_o, 1'b0);
        respond(2, 32'hDEADBEEF, 32'h10, n);
        chk("lw_stall_cycles", n, 3);

        // sw with immediate ack
        sb.push_back(mk(1'b0, 5'd9, 32'd0, 1'b0, 1'b1));
        issue(OP_SW, 32'h20, 32'h12345678, 32'h0, 5'd9, 1'b1);
        chk("sw_we", mem_bus.mem_we_o, 1'b1);
        chk("sw_wdata", mem_bus.mem_wdata_o, 32'h12345678);
        respond(0, 32'hFFFF0000, 32'h20, n);
        chk("sw_cycles", n, 1);

        // misaligned lw
        sb.push_back(mk(1'b0, 5'd4, 32'd0, 1'b1, 1'b0));
        issue(OP_LW, 32'h13, 32'h0, 32'h0, 5'd4, 1'b1);
        chk("mis_req", mem_bus.mem_req_o, 1'b0);
        chk("mis_stall", stall_o, 1'b0);

        // timeout: no ack
        sb.push_back(mk(1'b0, 5'd6, 32'd0, 1'b1, 1'b0));
        issue(OP_LW, 32'h44, 32'h0, 32'h0, 5'd6, 1'b1);
        respond(-1, 32'h0, 32'h44, n);
        chk("to_cycles", n, 16);

        // ack on the 16th WAIT cycle wins over timeout
        sb.push_back(mk(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 1'b1));
        issue(OP_LW, 32'h48, 32'h0, 32'h0, 5'd7, 1'b1);
        respond(15, 32'hCAFEF00D, 32'h48, n);
        chk("last_ack_cycles", n, 16);

        // reset on the 2nd WAIT cycle abandons the access
        issue(OP_LW, 32'h50, 32'h0, 32'h0, 5'd8, 1'b1);
        chk("rw_req", mem_bus.mem_req_o, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rw_req_async", mem_bus.mem_req_o, 1'b0);
        chk("rw_stall_async", stall_o, 1'b0);
        chk("rw_wb", wb_valid_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back(mk(1'b1, 5'd2, 32'h00000011, 1'b0, 1'b1));
        issue(OP_ADD, 32'h0, 32'h0, 32'h11, 5'd2, 1'b1);
        chk("post_rst_wb", wb_valid_o, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
